// File: rtl/sap1_control_sequencer.sv
// -----------------------------------------------------------------------------
// sap1_control_sequencer
//
// Control sequencer for the SAP-1 datapath. A six-state ring (T1..T6) steps
// each instruction through fetch (T1-T3) and execute (T4-T6). In every T-state
// the IR opcode is decoded into the active-high control word that drives the
// PC, MAR, RAM, IR, A, B, ALU and OUT registers. OP_HLT parks the sequencer in
// a HALT state that only mr can leave.
//
// Optional feature macro: SAP1_SEQ_EARLY_END_EN
//   defined   : each instruction ends at its last non-empty T-state
//               (LDA at T5, OUT and undefined opcodes at T4, ADD/SUB at T6)
//   undefined : every instruction takes all six T-states
//
// Ports
//   clk        in   rising-edge clock (divided system clock)
//   mr         in   asynchronous active-high master reset
//   run        in   clock enable; 0 freezes the state and forces controls to 0
//   opcode     in   IR[7:4]; only decoded in T4-T6
//   pc_inc     out  PC <= PC+1
//   pc_out     out  PC drives bus
//   mar_load   out  MAR <= bus[3:0]
//   ram_out    out  RAM[MAR] drives bus
//   ir_load    out  IR <= bus
//   ir_out     out  IR[3:0] drives bus
//   a_load     out  A <= bus
//   a_out      out  A drives bus
//   b_load     out  B <= bus
//   alu_sub    out  ALU computes A-B (0: A+B)
//   alu_out    out  ALU drives bus
//   out_load   out  OUT <= bus
//   tstate     out  one-hot T-state, bit0 = T1; all zero in HALT
//   halted     out  high in HALT
//   instr_done out  pulse in the final T-state of each executed instruction
// -----------------------------------------------------------------------------
module sap1_control_sequencer (
  input  logic       clk,
  input  logic       mr,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       out_load,
  output logic [5:0] tstate,
  output logic       halted,
  output logic       instr_done
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  state_e state_q;

  logic is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
  logic last_t;
  logic en;

  assign is_lda = (opcode == OP_LDA);
  assign is_add = (opcode == OP_ADD);
  assign is_sub = (opcode == OP_SUB);
  assign is_out = (opcode == OP_OUT);
  assign is_hlt = (opcode == OP_HLT);
  assign is_nop = ~(is_lda | is_add | is_sub | is_out | is_hlt);

  // Controls are live only while enabled and out of reset, so an asynchronous
  // mr kills any in-flight load before the next edge.
  assign en = run & ~mr;

  // Final T-state of the current instruction. T6 is always final so that a
  // mid-instruction opcode change can never leave the ring without a way home.
  always_comb begin
    last_t = 1'b0;
    case (state_q)
`ifdef SAP1_SEQ_EARLY_END_EN
      S_T4:    last_t = is_out | is_nop;
      S_T5:    last_t = is_lda;
`endif
      S_T6:    last_t = 1'b1;
      default: last_t = 1'b0;
    endcase
  end

  // NOTE: mr is in the sensitivity list so reset takes effect without a clock
  // edge; the state register uses non-blocking assignments only.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      state_q <= S_T1;
    end else if (run) begin
      case (state_q)
        S_T1:    state_q <= S_T2;
        S_T2:    state_q <= S_T3;
        S_T3:    state_q <= S_T4;
        S_T4:    state_q <= is_hlt ? S_HALT : (last_t ? S_T1 : S_T5);
        S_T5:    state_q <= last_t ? S_T1 : S_T6;
        S_T6:    state_q <= S_T1;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_T1;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred
  // for the states that leave a control untouched.
  always_comb begin
    pc_inc   = 1'b0;
    pc_out   = 1'b0;
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    alu_sub  = 1'b0;
    alu_out  = 1'b0;
    out_load = 1'b0;
    if (en) begin
      case (state_q)
        S_T1: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        S_T2: pc_inc = 1'b1;
        S_T3: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
        end
        S_T4: begin
          if (is_lda | is_add | is_sub) begin
            ir_out   = 1'b1;
            mar_load = 1'b1;
          end else if (is_out) begin
            a_out    = 1'b1;
            out_load = 1'b1;
          end
        end
        S_T5: begin
          if (is_lda) begin
            ram_out = 1'b1;
            a_load  = 1'b1;
          end else if (is_add | is_sub) begin
            ram_out = 1'b1;
            b_load  = 1'b1;
          end
        end
        S_T6: begin
          if (is_add | is_sub) begin
            alu_out = 1'b1;
            a_load  = 1'b1;
            alu_sub = is_sub;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      S_T1:    tstate = 6'b000001;
      S_T2:    tstate = 6'b000010;
      S_T3:    tstate = 6'b000100;
      S_T4:    tstate = 6'b001000;
      S_T5:    tstate = 6'b010000;
      S_T6:    tstate = 6'b100000;
      default: tstate = 6'b000000;
    endcase
  end

  assign halted     = (state_q == S_HALT);
  assign instr_done = en & last_t & ~is_hlt;

endmodule
